// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
// Load funct3 codes and register-file geometry.
package wb_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } ld_op_e;

endpackage

// File: rtl/wb_arbiter_load_ext.sv
// Load data extension for the writeback stage.
// Picks the byte/halfword lane and sign/zero-extends.
module load_ext
  import wb_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [31:0]        ld_raw,
  input  logic [2:0]         ld_funct3,
  input  logic [1:0]         ld_offset,
  output logic [D_WIDTH-1:0] ext_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane selection; halfword ignores offset bit 0.
  always_comb begin
    lane_b = ld_raw[{ld_offset, 3'b000} +: 8];
    lane_h = ld_offset[1] ? ld_raw[31:16]
                          : ld_raw[15:0];
  end

  // Extension by load type; unknown codes act as LW.
  always_comb begin
    ext_data = D_WIDTH'(ld_raw);
    case (ld_op_e'(ld_funct3))
      LB:  ext_data = {{(D_WIDTH-8){lane_b[7]}}, lane_b};
      LH:  ext_data = {{(D_WIDTH-16){lane_h[15]}}, lane_h};
      LBU: ext_data = D_WIDTH'(lane_b);
      LHU: ext_data = D_WIDTH'(lane_h);
      default: ext_data = D_WIDTH'(ld_raw);
    endcase
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: ALU/load arbitration, reg-file port, busy scoreboard.
// Optional WB_FWD_EN adds write-cycle bypass outputs.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int D_WIDTH      = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_valid,
  output logic               alu_ready,
  input  logic [REG_AW-1:0]  alu_rd,
  input  logic [D_WIDTH-1:0] alu_data,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [REG_AW-1:0]  ld_rd,
  input  logic [31:0]        ld_raw,
  input  logic [2:0]         ld_funct3,
  input  logic [1:0]         ld_offset,
  input  logic               iss_valid,
  input  logic [REG_AW-1:0]  iss_rd,
  input  logic [REG_AW-1:0]  rs1,
  input  logic [REG_AW-1:0]  rs2,
  output logic               rs1_busy,
  output logic               rs2_busy,
`ifdef WB_FWD_EN
  output logic               fwd1_hit,
  output logic               fwd2_hit,
  output logic [D_WIDTH-1:0] fwd1_data,
  output logic [D_WIDTH-1:0] fwd2_data,
`endif
  output logic               regStr,
  output logic [REG_AW-1:0]  rd,
  output logic [D_WIDTH-1:0] WBDat
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0]       starve_cnt;
  logic                starve_hit;
  logic                grant_ld;
  logic                grant_alu;
  logic                acc;
  logic [REG_AW-1:0]   acc_rd;
  logic [D_WIDTH-1:0]  acc_data;
  logic [D_WIDTH-1:0]  ld_ext;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;
  logic [NUM_REGS-1:0] busy_nxt;

  load_ext #(.D_WIDTH(D_WIDTH)) u_ext (
    .ld_raw    (ld_raw),
    .ld_funct3 (ld_funct3),
    .ld_offset (ld_offset),
    .ext_data  (ld_ext)
  );

  assign starve_hit = alu_valid && (starve_cnt == LIM);

  // Grant: load first unless the ALU has waited long enough.
  always_comb begin
    grant_ld  = 1'b0;
    grant_alu = 1'b0;
    if (starve_hit)
      grant_alu = 1'b1;
    else if (ld_valid)
      grant_ld = 1'b1;
    else if (alu_valid)
      grant_alu = 1'b1;
  end

  assign ld_ready  = grant_ld;
  assign alu_ready = grant_alu;
  assign acc       = grant_ld | grant_alu;
  assign acc_rd    = grant_ld ? ld_rd : alu_rd;
  assign acc_data  = grant_ld ? ld_ext : alu_data;

  // Count consecutive denied ALU cycles, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      starve_cnt <= '0;
    else if (!alu_valid || grant_alu)
      starve_cnt <= '0;
    else if (starve_cnt != LIM)
      starve_cnt <= starve_cnt + 1'b1;
  end

  // Register the accepted beat; x0 writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regStr <= 1'b0;
      rd     <= '0;
      WBDat  <= '0;
    end else if (acc && (acc_rd != '0)) begin
      regStr <= 1'b1;
      rd     <= acc_rd;
      WBDat  <= acc_data;
    end else begin
      regStr <= 1'b0;
    end
  end

  // Scoreboard update masks; set beats clear on the same reg.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (iss_valid)
      set_mask[iss_rd] = 1'b1;
    if (regStr)
      clr_mask[rd] = 1'b1;
    busy_nxt    = (busy & ~clr_mask) | set_mask;
    busy_nxt[0] = 1'b0;
  end

  // Busy bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

`ifdef WB_FWD_EN
  assign fwd1_hit  = regStr && (rd == rs1) && (rs1 != '0);
  assign fwd2_hit  = regStr && (rd == rs2) && (rs2 != '0);
  assign fwd1_data = WBDat;
  assign fwd2_data = WBDat;
  assign rs1_busy  = busy[rs1] & ~fwd1_hit;
  assign rs2_busy  = busy[rs2] & ~fwd2_hit;
`else
  assign rs1_busy  = busy[rs1];
  assign rs2_busy  = busy[rs2];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter.
// Inputs change 1ns after posedge; checks 1ns later.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_raw;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        iss_valid;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        regStr;
  logic [4:0]  rd;
  logic [31:0] WBDat;
`ifdef WB_FWD_EN
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [9:0] alu_pat;

  always #5 clk = ~clk;

  wb_arbiter #(.D_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_raw    (ld_raw),
    .ld_funct3 (ld_funct3),
    .ld_offset (ld_offset),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
`ifdef WB_FWD_EN
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
`endif
    .regStr    (regStr),
    .rd        (rd),
    .WBDat     (WBDat)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag,
                         input logic [2:0] f3,
                         input logic [1:0] off,
                         input logic [4:0] dst,
                         input logic [31:0] exp);
    ld_valid  = 1'b1;
    ld_rd     = dst;
    ld_funct3 = f3;
    ld_offset = off;
    #1;
    chk({tag, "_ready"}, 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    #1;
    chk({tag, "_str"}, 32'(regStr), 32'd1);
    chk({tag, "_rd"}, 32'(rd), 32'(dst));
    chk({tag, "_dat"}, WBDat, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_raw = '0;
    ld_funct3 = 3'b010; ld_offset = '0;
    iss_valid = 1'b0; iss_rd = '0;
    rs1 = 5'd7; rs2 = 5'd7;
    alu_pat = 10'b10000_10000;

    tick(); tick();
    chk("rst_regStr", 32'(regStr), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wbdat", WBDat, 32'd0);
    chk("rst_busy", 32'(rs1_busy), 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU only
    alu_valid = 1'b1; alu_rd = 5'd5;
    alu_data = 32'h0000_1234;
    #1;
    chk("alu_ready", 32'(alu_ready), 32'd1);
    chk("alu_ld_ready", 32'(ld_ready), 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("alu_str", 32'(regStr), 32'd1);
    chk("alu_rd", 32'(rd), 32'd5);
    chk("alu_dat", WBDat, 32'h0000_1234);

    // x0 write: handshake, no strobe, hold
    alu_valid = 1'b1; alu_rd = 5'd0;
    alu_data = 32'hDEAD_BEEF;
    iss_valid = 1'b1; iss_rd = 5'd0; rs2 = 5'd0;
    #1;
    chk("x0_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 1'b0; iss_valid = 1'b0;
    #1;
    chk("x0_str", 32'(regStr), 32'd0);
    chk("x0_rd_hold", 32'(rd), 32'd5);
    chk("x0_dat_hold", WBDat, 32'h0000_1234);
    chk("x0_busy", 32'(rs2_busy), 32'd0);

    // Load extension
    ld_raw = 32'h80FF_7F01;
    do_load("lb3", 3'b000, 2'd3, 5'd10, 32'hFFFF_FF80);
    do_load("lbu2", 3'b100, 2'd2, 5'd11, 32'h0000_00FF);
    do_load("lh2", 3'b001, 2'd2, 5'd12, 32'hFFFF_80FF);
    do_load("lhu0", 3'b101, 2'd0, 5'd13, 32'h0000_7F01);
    do_load("lw", 3'b010, 2'd1, 5'd14, 32'h80FF_7F01);
    do_load("f3_7", 3'b111, 2'd0, 5'd15, 32'h80FF_7F01);
    tick();
    chk("idle_str", 32'(regStr), 32'd0);
    chk("idle_rd_hold", 32'(rd), 32'd15);

    // Contention: ALU every fifth cycle
    ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = 3'b010;
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_00AA;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk($sformatf("cont_alu%0d", c),
          32'(alu_ready), 32'(alu_pat[c]));
      chk($sformatf("cont_ld%0d", c),
          32'(ld_ready), 32'(!alu_pat[c]));
      @(posedge clk);
      #1;
      chk($sformatf("cont_rd%0d", c), 32'(rd),
          alu_pat[c] ? 32'd4 : 32'd3);
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    tick();

    // Scoreboard set and clear
    rs1 = 5'd7; rs2 = 5'd7;
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    chk("sb_pre", 32'(rs1_busy), 32'd0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("sb_set", 32'(rs1_busy), 32'd1);
    chk("sb_set2", 32'(rs2_busy), 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7;
    tick();
    ld_valid = 1'b0;
    #1;
    chk("sb_wr_str", 32'(regStr), 32'd1);
    chk("sb_wr_busy", 32'(rs1_busy), FWD ? 32'd0 : 32'd1);
    tick();
    chk("sb_clr", 32'(rs1_busy), 32'd0);

    // Set wins over same-cycle clear
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    iss_valid = 1'b1;
    #1;
    chk("sw_str", 32'(regStr), 32'd1);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("sw_busy", 32'(rs1_busy), 32'd1);

    // Reset mid-flight
    rs1 = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12;
    alu_data = 32'h0000_0055;
    #1;
    chk("mr_busy", 32'(rs1_busy), 32'd1);
    chk("mr_ready", 32'(alu_ready), 32'd1);
    #1;
    rst_n = 1'b0;
    alu_valid = 1'b0;
    #1;
    chk("mr_str", 32'(regStr), 32'd0);
    chk("mr_rd", 32'(rd), 32'd0);
    chk("mr_dat", WBDat, 32'd0);
    chk("mr_rs1", 32'(rs1_busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_post_str", 32'(regStr), 32'd0);
    chk("mr_post_rd", 32'(rd), 32'd0);
    tick();
    chk("mr_post_str2", 32'(regStr), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback stage that produces the register-file write port (regStr, rd, WBDat) for the reg32Blk register file.
- Arbitrates between two result producers, the ALU and the load unit, using valid/ready handshakes.
- Sign- or zero-extends load data.
- Keeps a 32-entry busy scoreboard so decode knows when it may assert regLd for rs1/rs2.

Parameters:
- D_WIDTH, 32, data width of results and WBDat.
- STARVE_LIMIT, 4, number of consecutive denied ALU cycles before the ALU gets priority for one cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  5  ALU destination register.
- alu_data  in  D_WIDTH  ALU result.
- ld_valid  in  1  load result valid.
- ld_ready  out  1  load result accepted this cycle.
- ld_rd  in  5  load destination register.
- ld_raw  in  32  raw aligned memory word.
- ld_funct3  in  3  load type.
- ld_offset  in  2  byte address [1:0].
- iss_valid  in  1  an instruction writing iss_rd is issued this cycle.
- iss_rd  in  5  issued destination register.
- rs1  in  5  decode query register 1.
- rs2  in  5  decode query register 2.
- rs1_busy  out  1  rs1 has a pending write.
- rs2_busy  out  1  rs2 has a pending write.
- regStr  out  1  register-file write strobe.
- rd  out  5  register-file write address.
- WBDat  out  D_WIDTH  register-file write data.

Behaviour:
Reset values:
- regStr=0, rd=0, WBDat=0.
- All busy bits 0, starvation counter 0.
- Reset mid-operation discards any in-flight beat; no write is issued after reset release.

Arbitration (combinational grant):
- Load has fixed priority.
- Exception: if starve_cnt==STARVE_LIMIT and alu_valid, the ALU is granted.
- ld_ready = grant_ld; alu_ready = grant_alu. At most one is high.
- Ready may depend on valid. No backpressure from the register file, so one beat is accepted per cycle whenever any valid is high.

Starvation counter:
- Increments when alu_valid and not granted, saturating at STARVE_LIMIT.
- Clears when the ALU is granted or alu_valid=0.

Output register (latency 1):
- A beat accepted in cycle N drives regStr/rd/WBDat in cycle N+1.
- regStr=1 only if the accepted rd != 0. For rd==0 the handshake completes, regStr stays 0, and rd/WBDat hold their previous values.
- With no accepted beat, regStr=0 and rd/WBDat hold.

Load extension (lane = ld_offset):
- 000 LB: sign-extend byte at lane.
- 001 LH: sign-extend halfword at ld_offset[1]; ld_offset[0] ignored.
- 010 LW: full word.
- 100 LBU: zero-extend byte at lane.
- 101 LHU: zero-extend halfword at ld_offset[1].
- Any other funct3: treated as LW.

Scoreboard:
- iss_valid with iss_rd != 0 sets busy[iss_rd] at the clock edge.
- The cycle in which regStr=1 clears busy[rd] at the end of that cycle.
- Simultaneous set and clear of the same register: set wins.
- busy[0] is always 0.
- rsX_busy = busy[rsX], registered, so decode's regLd in the cycle after regStr reads the new value.

Optional Feature:
- Macro: WB_FWD_EN.
- With it defined, add ports fwd1_hit/fwd2_hit (out 1) and fwd1_data/fwd2_data (out D_WIDTH).
  - fwdX_hit = regStr & (rd==rsX) & (rsX!=0); fwdX_data = WBDat.
  - rsX_busy is forced 0 when fwdX_hit, letting decode bypass in the write cycle.
- Without it, the ports do not exist and rsX_busy is purely the busy bit.

Decomposition:
- Package wb_pkg holds:
  - typedef enum of load funct3 codes: LB, LH, LW, LBU, LHU.
  - localparam NUM_REGS=32 and REG_AW=5.
- Sub-module load_ext: purely combinational (ld_raw, ld_funct3, ld_offset) -> D_WIDTH extended data; instantiated once.

Test Plan:
- ALU only: alu_valid=1, alu_rd=5, alu_data=0x1234 -> alu_ready=1 same cycle; next cycle regStr=1, rd=5, WBDat=0x1234.
- Load extension: ld_raw=0x80FF7F01.
  - LB offset 3 -> WBDat=0xFFFFFF80.
  - LBU offset 2 -> 0x000000FF.
  - LH offset 2 -> 0xFFFF80FF.
  - LHU offset 0 -> 0x00007F01.
- Contention: ld_valid and alu_valid both held high continuously -> loads granted for 4 cycles, ALU granted on cycle 5, then loads again; the ALU pulses repeat every 5 cycles.
- x0 write: alu_rd=0 -> alu_ready=1 and regStr stays 0 next cycle; iss_valid with iss_rd=0 -> busy never set.
- Scoreboard:
  - iss_rd=7 issued, then rs1=7 -> rs1_busy=1.
  - Load to rd 7 is accepted; regStr is asserted the next cycle; rs1_busy=0 in the following cycle.
  - iss_rd=7 issued in the same cycle as regStr for rd 7 -> rs1_busy stays 1.
- Reset mid-flight: beat accepted, rst_n=0 before the next edge -> regStr=0, rd=0, WBDat=0, rs1_busy=0; no write after release.
